// File: rtl/uart_hex_line_parser.sv
// rtl/uart_hex_line_parser.sv - parses CR/LF terminated ASCII hex lines from a UART byte stream into words
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   rx_done    one-cycle strobe, rx_data holds a new byte
//   rx_data    received byte
//   out_valid  one-cycle strobe, out_data/out_len hold a newly parsed word
//   out_data   parsed value, right-aligned, zero-extended, held between strobes
//   out_len    number of hex digits in the parsed word, held with out_data
//   err        one-cycle strobe, current line rejected (bad char or too many digits)

module uart_hex_line_parser #(
   parameter  int WIDTH = 32,
   localparam int MAXD  = WIDTH / 4,
   localparam int LW    = $clog2(MAXD + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_done,
   input  logic [7:0]       rx_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [LW-1:0]    out_len,
   output logic             err
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCUM   = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [LW-1:0]    cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [LW-1:0]    out_len_q, out_len_d;

   logic             is_digit;
   logic             is_term;
   logic             is_sep;
   logic [3:0]       nibble;

   // Character classification; anything not matched here (including >=0x80) is BAD.
   always_comb begin
      is_digit = 1'b0;
      is_term  = 1'b0;
      is_sep   = 1'b0;
      nibble   = 4'd0;
      if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
         is_digit = 1'b1;
         nibble   = rx_data[3:0];
      end else if ((rx_data >= 8'h61 && rx_data <= 8'h66) ||
                   (rx_data >= 8'h41 && rx_data <= 8'h46)) begin
         // 'a'/'A' have low nibble 1, so +9 maps them onto 10
         is_digit = 1'b1;
         nibble   = rx_data[3:0] + 4'd9;
      end else if (rx_data == 8'h0A || rx_data == 8'h0D) begin
         is_term  = 1'b1;
      end else if (rx_data == 8'h20 || rx_data == 8'h09 || rx_data == 8'h5F) begin
         is_sep   = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
      out_data_d  = out_data_q;
      out_len_d   = out_len_q;

      if (rx_done) begin
         case (state_q)
            ST_IDLE: begin
               if (is_digit) begin
                  acc_d   = {{(WIDTH-4){1'b0}}, nibble};
                  cnt_d   = LW'(1);
                  state_d = ST_ACCUM;
               end else if (!is_sep && !is_term) begin
                  err_d   = 1'b1;
                  state_d = ST_DISCARD;
               end
            end
            ST_ACCUM: begin
               if (is_digit) begin
                  if (cnt_q == LW'(MAXD)) begin
                     // one digit too many for the output word
                     err_d   = 1'b1;
                     state_d = ST_DISCARD;
                  end else begin
                     acc_d = {acc_q[WIDTH-5:0], nibble};
                     cnt_d = cnt_q + LW'(1);
                  end
               end else if (is_term) begin
                  out_data_d  = acc_q;
                  out_len_d   = cnt_q;
                  out_valid_d = 1'b1;
                  acc_d       = '0;
                  cnt_d       = '0;
                  state_d     = ST_IDLE;
               end else if (!is_sep) begin
                  err_d   = 1'b1;
                  state_d = ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               // err already reported for this line; just wait for its end
               if (is_term) begin
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end
            default: begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         out_data_q  <= '0;
         out_len_q   <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         out_data_q  <= out_data_d;
         out_len_q   <= out_len_d;
      end
   end

   assign out_valid = out_valid_q;
   assign err       = err_q;
   assign out_data  = out_data_q;
   assign out_len   = out_len_q;

endmodule

// File: tb/tb_uart_hex_line_parser.sv
// tb/tb_uart_hex_line_parser.sv - scoreboard bench for uart_hex_line_parser

module tb_uart_hex_line_parser;

   localparam int WIDTH = 32;
   localparam int MAXD  = WIDTH / 4;
   localparam int LW    = $clog2(MAXD + 1);

   localparam int K_RST = 0;
   localparam int K_VAL = 1;
   localparam int K_ERR = 2;

   typedef struct {
      int          kind;
      logic [63:0] data;
      int          len;
      int          cyc;
   } ev_t;

   logic             clk;
   logic             rst_n;
   logic             rx_done;
   logic [7:0]       rx_data;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [LW-1:0]    out_len;
   logic             err;

   uart_hex_line_parser #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_done   (rx_done),
      .rx_data   (rx_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_len   (out_len),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int  nchk  = 0;
   int  npass = 0;
   ev_t q[$];
   bit  mon_en = 1'b0;

   // reference model state: digits of the current line, and whether it is already rejected
   int  digits[$];
   bit  rejected = 1'b0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (ok) npass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int hexval(input logic [7:0] b);
      if (b >= "0" && b <= "9") return int'(b) - 48;
      if (b >= "a" && b <= "f") return int'(b) - 97 + 10;
      if (b >= "A" && b <= "F") return int'(b) - 65 + 10;
      return -1;
   endfunction

   task automatic push_ev(input int kind, input logic [63:0] data, input int len, input int ecyc);
      ev_t e;
      e.kind = kind;
      e.data = data;
      e.len  = len;
      e.cyc  = ecyc;
      q.push_back(e);
   endtask

   task automatic model_byte(input logic [7:0] b, input int ecyc);
      int          h;
      logic [63:0] v;
      bit          term, sep;
      h    = hexval(b);
      term = (b == 8'h0A || b == 8'h0D);
      sep  = (b == 8'h20 || b == 8'h09 || b == 8'h5F);
      if (rejected) begin
         if (term) begin
            rejected = 1'b0;
            digits.delete();
         end
      end else if (h >= 0) begin
         if (digits.size() == MAXD) begin
            push_ev(K_ERR, 64'd0, 0, ecyc);
            rejected = 1'b1;
         end else begin
            digits.push_back(h);
         end
      end else if (term) begin
         if (digits.size() > 0) begin
            v = 64'd0;
            foreach (digits[i]) v = v * 16 + 64'(digits[i]);
            push_ev(K_VAL, v, digits.size(), ecyc);
         end
         digits.delete();
      end else if (!sep) begin
         push_ev(K_ERR, 64'd0, 0, ecyc);
         rejected = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         rx_done = 1'b0;
         rx_data = 8'($urandom);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      idle(gap);
      @(posedge clk);
      #1;
      rx_done = 1'b1;
      rx_data = b;
      model_byte(b, cyc + 1);
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
      idle(2);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n   = 1'b0;
      rx_done = 1'b0;
      push_ev(K_RST, 64'd0, 0, cyc + 1);
      digits.delete();
      rejected = 1'b0;
      mon_en   = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // monitor / scoreboard
   logic [WIDTH-1:0] hold_data = '0;
   logic [LW-1:0]    hold_len  = '0;
   ev_t              e;

   always @(negedge clk) begin
      if (mon_en) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk(1'b0, "missed_event", 64'(e.cyc), 64'(e.kind));
         end
         if (q.size() > 0 && q[0].kind == K_RST && q[0].cyc == cyc) begin
            e = q.pop_front();
            hold_data = '0;
            hold_len  = '0;
            chk(out_data == '0 && out_len == '0, "reset_outputs", 64'(out_data), 64'd0);
            chk(!out_valid && !err, "reset_strobes", {62'd0, out_valid, err}, 64'd0);
         end
         if (out_valid || err) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
               e = q.pop_front();
               if (e.kind == K_VAL) begin
                  chk(out_valid && !err, "valid_strobe", {62'd0, out_valid, err}, 64'd2);
                  chk(out_data == e.data[WIDTH-1:0], "out_data", 64'(out_data), e.data);
                  chk(int'(out_len) == e.len, "out_len", 64'(out_len), 64'(e.len));
                  hold_data = e.data[WIDTH-1:0];
                  hold_len  = LW'(e.len);
               end else begin
                  chk(err && !out_valid, "err_strobe", {62'd0, out_valid, err}, 64'd1);
               end
            end else begin
               chk(1'b0, "unexpected_strobe", {62'd0, out_valid, err}, 64'd0);
            end
         end else if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk(1'b0, "missing_strobe", 64'd0, 64'(e.kind));
         end
         chk(out_data == hold_data && out_len == hold_len, "held_output",
             {28'd0, out_len, out_data}, {28'd0, hold_len, hold_data});
      end
   end

   initial begin
      string hexch;
      string s;
      int    n, r;
      hexch   = "0123456789abcdefABCDEF";
      rst_n   = 1'b0;
      rx_done = 1'b0;
      rx_data = 8'h00;
      do_reset();
      idle(2);

      send_str("1A2b\012", 0);
      send_str("DEAD_BEEF\015\012", 1);
      send_str("123456789\012", 0);
      send_str("7\012", 0);
      send_str("12G4\012", 2);
      send_str("\012\015  \012", 0);
      send_str("00000001\012", 0);
      send_str("\tff ab\015", 1);
      send_byte(8'h85, 0);
      send_str("3\012", 0);

      // mid-line reset, back-to-back and widely spaced bytes
      send_str("AB", 0);
      do_reset();
      send_str("C\012", 0);
      send_str("AB", 1000);
      do_reset();
      send_str("C\012", 1000);

      for (int line = 0; line < 300; line++) begin
         n = $urandom_range(0, 11);
         for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      send_byte(hexch[$urandom_range(0, 21)], $urandom_range(0, 2));
            else if (r < 82) send_byte((r < 76) ? 8'h20 : ((r < 79) ? 8'h09 : 8'h5F), $urandom_range(0, 2));
            else if (r < 85) send_byte(($urandom_range(0, 1) == 1) ? 8'h0A : 8'h0D, 0);
            else             send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 2));
         end
         r = $urandom_range(0, 2);
         if (r == 0)      send_byte(8'h0A, $urandom_range(0, 1));
         else if (r == 1) send_byte(8'h0D, $urandom_range(0, 1));
         else begin
            send_byte(8'h0D, 0);
            send_byte(8'h0A, 0);
         end
         if ($urandom_range(0, 9) == 0) idle(5);
      end

      idle(5);
      chk(q.size() == 0, "queue_drained", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
